// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronizer, oversampled start/data/stop sampling,
// one-clock rx_valid / frame_err strobes and a break-hold state.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SAMPLING  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bclk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(SAMPLING);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] MID   = TW'(SAMPLING / 2 - 1);
    localparam logic [TW-1:0] LAST  = TW'(SAMPLING - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t                 state, state_n;
    logic [1:0]             sync;
    logic                   rx_s;
    logic [TW-1:0]          tick, tick_n;
    logic [BW-1:0]          bits, bits_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic [DATA_BITS-1:0]   data_n;
    logic                   valid_n, err_n;

    assign rx_s = sync[1];
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync      <= 2'b11;
            state     <= IDLE;
            tick      <= '0;
            bits      <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[0], rx};
            state     <= state_n;
            tick      <= tick_n;
            bits      <= bits_n;
            shift     <= shift_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = bclk ? tick + 1'b1 : tick;
        bits_n  = bits;
        shift_n = shift;
        data_n  = rx_data;
        valid_n = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                tick_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                // midpoint check rejects glitches shorter than half a bit
                if (bclk && tick == MID) begin
                    tick_n  = '0;
                    bits_n  = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bclk && tick == LAST) begin
                    tick_n  = '0;
                    shift_n = {rx_s, shift[DATA_BITS-1:1]};
                    bits_n  = bits + 1'b1;
                    if (bits == BLAST) state_n = STOP;
                end
            end
            STOP: begin
                if (bclk && tick == LAST) begin
                    tick_n = '0;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = BRK;
                    end
                end
            end
            BRK: begin
                // wait for the line to go idle so a held-low line is not re-read
                tick_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                tick_n  = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean, back-to-back, false start,
// framing error, mid-frame reset and a 5-bit / 8x-sampling instance.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bclk = 1'b0;
    logic [2:0] bc = 3'd0;
    logic       rx = 1'b1;
    logic       rx2 = 1'b1;

    logic [7:0] rx_data;
    logic       rx_valid, frame_err, busy;
    logic [4:0] rx_data2;
    logic       rx_valid2, frame_err2, busy2;

    int compared = 0;
    int mismatched = 0;
    int nval = 0, nerr = 0, nboth = 0;
    int nval2 = 0, nerr2 = 0;

    uart_rx #(.DATA_BITS(8), .SAMPLING(16)) dut (
        .clk(clk), .reset(reset), .bclk(bclk), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_err(frame_err), .busy(busy)
    );

    uart_rx #(.DATA_BITS(5), .SAMPLING(8)) dut2 (
        .clk(clk), .reset(reset), .bclk(bclk), .rx(rx2),
        .rx_data(rx_data2), .rx_valid(rx_valid2),
        .frame_err(frame_err2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // one-clock bclk pulse every 6 clocks
    always @(posedge clk) begin
        bc   <= (bc == 3'd5) ? 3'd0 : bc + 3'd1;
        bclk <= (bc == 3'd5);
    end

    always @(negedge clk) begin
        if (rx_valid) nval++;
        if (frame_err) nerr++;
        if (rx_valid && frame_err) nboth++;
        if (rx_valid2) nval2++;
        if (frame_err2) nerr2++;
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!bclk) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rx = v;
        else rx2 = v;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d,
                              input int nb, input int spb,
                              input logic stopb);
        logic [7:0] dv;
        dv = d;
        drive(which, 1'b0);
        ticks(spb);
        for (int i = 0; i < nb; i++) begin
            drive(which, dv[i]);
            ticks(spb);
        end
        drive(which, stopb);
        ticks(spb);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[4];
    int   v0, e0;
    logic [7:0] c3 = 8'hC3;

    initial begin
        tbl[0] = '{8'hA5, 8'hA5};
        tbl[1] = '{8'h00, 8'h00};
        tbl[2] = '{8'hFF, 8'hFF};
        tbl[3] = '{8'h3C, 8'h3C};

        repeat (4) @(posedge clk);
        #1;
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        check("reset_busy2", busy2, 0);
        reset = 1'b0;
        ticks(4);

        // clean frame then back-to-back frames with no idle gap
        for (int i = 0; i < 4; i++) begin
            v0 = nval;
            e0 = nerr;
            send_frame(0, tbl[i].data, 8, 16, 1'b1);
            check($sformatf("tbl%0d_valid", i), nval - v0, 1);
            check($sformatf("tbl%0d_err", i), nerr - e0, 0);
            check($sformatf("tbl%0d_data", i), rx_data, tbl[i].exp);
        end
        ticks(4);
        check("idle_busy", busy, 0);

        // false start: 4 ticks low
        v0 = nval;
        e0 = nerr;
        rx = 1'b0;
        ticks(4);
        rx = 1'b1;
        ticks(16);
        check("false_busy", busy, 0);
        check("false_valid", nval - v0, 0);
        check("false_err", nerr - e0, 0);
        send_frame(0, 8'h5A, 8, 16, 1'b1);
        check("5a_valid", nval - v0, 1);
        check("5a_data", rx_data, 8'h5A);

        // framing error followed by a held-low line
        v0 = nval;
        e0 = nerr;
        send_frame(0, 8'h81, 8, 16, 1'b0);
        ticks(48);
        check("ferr_err", nerr - e0, 1);
        check("ferr_valid", nval - v0, 0);
        check("ferr_data", rx_data, 8'h5A);
        check("ferr_busy_brk", busy, 1);
        rx = 1'b1;
        ticks(16);
        check("ferr_busy_rel", busy, 0);
        check("ferr_no_more", nerr - e0, 1);
        send_frame(0, 8'h42, 8, 16, 1'b1);
        check("42_valid", nval - v0, 1);
        check("42_data", rx_data, 8'h42);

        // reset during data bit 4 of 0xC3
        v0 = nval;
        e0 = nerr;
        rx = 1'b0;
        ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = c3[i];
            ticks(16);
        end
        rx = c3[4];
        ticks(5);
        reset = 1'b1;
        #1;
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        rx = 1'b1;
        ticks(3);
        reset = 1'b0;
        ticks(16);
        send_frame(0, 8'h99, 8, 16, 1'b1);
        check("99_valid", nval - v0, 1);
        check("99_err", nerr - e0, 0);
        check("99_data", rx_data, 8'h99);

        // DATA_BITS=5, SAMPLING=8 instance
        send_frame(1, 8'h15, 5, 8, 1'b1);
        ticks(4);
        check("p5_data", rx_data2, 5'h15);
        check("p5_valid", nval2, 1);
        check("p5_err", nerr2, 0);
        check("p5_busy", busy2, 0);

        check("never_both", nboth, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART serial receiver driven by the 16x-oversampling tick from the baud tick generator.
- Synchronizes the asynchronous `rx` line, detects the start bit, validates it at mid-bit, then samples data bits LSB-first at bit centres.
- Checks the stop bit and presents each received byte with a one-clock valid strobe, or a framing-error strobe if the stop bit is bad.
- Sits between the pad/pin and the host-side consumer (FIFO or register interface).

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8 supported).
- SAMPLING, 16, bclk ticks per bit period; must be even and >= 4.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- bclk  input  1  one-clk-wide enable pulse at BAUD_RATE*SAMPLING, from the baud tick generator.
- rx  input  1  asynchronous serial input, idle high.
- rx_data  output  DATA_BITS  last correctly framed byte.
- rx_valid  output  1  one-clk pulse: rx_data updated.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- busy  output  1  high while a frame is in progress (any state but IDLE).

Behaviour:
- Reset (async, active-high):
  - state=IDLE, tick counter=0, bit counter=0, shift register=0.
  - Synchronizer flops = 1 (idle level).
  - rx_data=0, rx_valid=0, frame_err=0, busy=0.
- Synchronizer: `rx` passes through a 2-FF synchronizer; all logic uses the synchronized value `rx_s`, which adds 2 clk latency.
- Tick counter:
  - Advances only on clk edges where bclk=1.
  - Width is ceil(log2(SAMPLING)).
  - Cleared on every state transition.
- IDLE: on any clk with rx_s=0, go to START and clear the tick counter. bclk is not required for this transition.
- START:
  - On the bclk tick where the counter reaches SAMPLING/2-1 (the start-bit midpoint), sample rx_s.
  - rx_s=0: go to DATA, bit counter=0.
  - rx_s=1: false start, return to IDLE. No strobes.
- DATA:
  - Every SAMPLING ticks (counter reaches SAMPLING-1), sample rx_s.
  - Shift it into the MSB of the shift register (right shift, LSB-first reception).
  - Increment the bit counter; after DATA_BITS samples go to STOP.
- STOP: after SAMPLING ticks, sample rx_s.
  - rx_s=1: rx_data<=shift register, rx_valid=1 for exactly one clk, go to IDLE.
  - rx_s=0: frame_err=1 for exactly one clk, rx_data unchanged, go to BREAK.
- BREAK: remain until rx_s=1, then go to IDLE. This prevents a held-low line from being re-read as back-to-back 0x00 frames.
- Strobes: rx_valid and frame_err are registered outputs and are never high simultaneously.
- Latency: the strobe asserts on the clk edge following the bclk tick that samples the stop-bit midpoint.
- Back-to-back frames: a start edge immediately after the stop-bit midpoint is accepted, because IDLE is re-entered half a bit before the stop bit ends.
- bclk stuck low: the FSM holds its state indefinitely with no timeout, and outputs hold.
- Reset mid-frame: the frame is discarded, no strobe is issued, and all values revert to reset values on the next cycle.
- Glitch shorter than SAMPLING/2 ticks on an idle line: rejected via the START midpoint check.

Test Plan:
- Clean frame: reset, then send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at bclk every 6 clk with SAMPLING=16. Required: rx_data=0xA5, one rx_valid pulse, frame_err never asserts, busy low afterwards.
- Back-to-back frames: send 0x00, 0xFF, 0x3C with no idle gap. Required: three rx_valid pulses with rx_data 0x00, 0xFF, 0x3C in order.
- False start: pull rx low for 4 bclk ticks, then high. Required: FSM returns to IDLE, no strobes; a subsequent 0x5A is received correctly.
- Framing error: send 0x81 with the stop bit low, then hold rx low for 3 bit times, then release. Required: exactly one frame_err pulse, rx_data keeps its previous value, no further strobes until rx returns high; the next 0x42 is received correctly.
- Reset mid-frame: assert reset during data bit 4 of 0xC3. Required: all outputs 0 immediately (async). After release, 0x99 is received correctly and no strobe appears for the aborted frame.
- Parameter corner: DATA_BITS=5, SAMPLING=8, send 0x15. Required: rx_data=5'h15 with one rx_valid pulse.
